// File: rtl/delay_and_sum.sv
// Per-channel circular sample history with programmable frame delays; each accepted frame
// yields one full-precision signed sum of the delayed channel samples.
module delay_and_sum #(
   parameter int NUM_CHANNELS = 2,
   parameter int SAMPLE_BITS  = 8,
   parameter int DEPTH        = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         sample_valid,
   input  logic [NUM_CHANNELS*SAMPLE_BITS-1:0]          sample_data,
   input  logic                                         cfg_load,
   input  logic [NUM_CHANNELS*$clog2(DEPTH)-1:0]        delay_cfg,
   output logic                                         out_valid,
   output logic [SAMPLE_BITS+$clog2(NUM_CHANNELS)-1:0]  out_data,
   output logic                                         busy,
   output logic                                         overrun
);

   localparam int DW       = $clog2(DEPTH);
   localparam int OUT_BITS = SAMPLE_BITS + $clog2(NUM_CHANNELS);
   localparam int CW       = $clog2(NUM_CHANNELS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_ACCUM,
      S_DONE
   } state_t;

   state_t                             state_q, state_d;
   logic [DW-1:0]                      wr_ptr_q, wr_ptr_d;
   logic [DW-1:0]                      cap_ptr_q, cap_ptr_d;
   logic [DW:0]                        fill_q, fill_d;
   logic [NUM_CHANNELS-1:0][DW-1:0]    delay_q, delay_d;
   logic [NUM_CHANNELS-1:0][DW-1:0]    pend_q, pend_d;
   logic                               pend_valid_q, pend_valid_d;
   logic [CW-1:0]                      ch_q, ch_d;
   logic [OUT_BITS-1:0]                acc_q, acc_d;
   logic                               out_valid_q, out_valid_d;
   logic [OUT_BITS-1:0]                out_data_q, out_data_d;
   logic                               overrun_q, overrun_d;
   logic                               wr_en;

   logic [OUT_BITS-1:0]                term [NUM_CHANNELS];

   // One history RAM per channel. Every channel reads its delayed entry each cycle; the
   // address is stable from WRITE onwards, so the registered data is ready throughout ACCUM.
   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
         logic [SAMPLE_BITS-1:0] mem [DEPTH];
         logic [SAMPLE_BITS-1:0] rd_q;
         logic [DW-1:0]          rd_addr;
         logic                   in_range;

         assign rd_addr  = cap_ptr_q - delay_q[gi];
         assign in_range = ({1'b0, delay_q[gi]} < fill_q);

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_ptr_q] <= sample_data[gi*SAMPLE_BITS +: SAMPLE_BITS];
            end
            rd_q <= mem[rd_addr];
         end

         // Entries older than the fill count were never written since reset; they count as 0.
         assign term[gi] = in_range ? {{(OUT_BITS-SAMPLE_BITS){rd_q[SAMPLE_BITS-1]}}, rd_q}
                                    : '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         cap_ptr_q    <= '0;
         fill_q       <= '0;
         delay_q      <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         ch_q         <= '0;
         acc_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         cap_ptr_q    <= cap_ptr_d;
         fill_q       <= fill_d;
         delay_q      <= delay_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         ch_q         <= ch_d;
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overrun_q    <= overrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      cap_ptr_d    = cap_ptr_q;
      fill_d       = fill_q;
      delay_d      = delay_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      ch_d         = ch_q;
      acc_d        = acc_q;
      out_valid_d  = 1'b0;
      out_data_d   = out_data_q;
      overrun_d    = overrun_q;
      wr_en        = 1'b0;

      if (cfg_load) begin
         pend_d       = delay_cfg;
         pend_valid_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // Delays only change here, so a frame in flight never sees a mixed set.
            if (cfg_load) begin
               delay_d      = delay_cfg;
               pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
               delay_d      = pend_q;
               pend_valid_d = 1'b0;
            end
            if (sample_valid) begin
               wr_en     = 1'b1;
               cap_ptr_d = wr_ptr_q;
               wr_ptr_d  = wr_ptr_q + DW'(1);
               fill_d    = (fill_q == (DW+1)'(DEPTH)) ? fill_q : fill_q + (DW+1)'(1);
               acc_d     = '0;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            ch_d    = '0;
            state_d = S_ACCUM;
         end
         S_ACCUM: begin
            acc_d = acc_q + term[ch_q];
            ch_d  = ch_q + CW'(1);
            if (ch_q == CW'(NUM_CHANNELS-1)) begin
               out_data_d  = acc_q + term[ch_q];
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (sample_valid && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_delay_and_sum.sv
// Randomised bench for delay_and_sum: a frame-history model predicts every sum, latency,
// busy window and the sticky overrun flag.
module tb_delay_and_sum;
   localparam int NC    = 2;
   localparam int SB    = 8;
   localparam int DEPTH = 16;
   localparam int DW    = 4;
   localparam int OB    = 9;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             sample_valid = 1'b0;
   logic             cfg_load = 1'b0;
   logic [NC*SB-1:0] sample_data = '0;
   logic [NC*DW-1:0] delay_cfg = '0;
   logic             out_valid;
   logic [OB-1:0]    out_data;
   logic             busy;
   logic             overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int hist0[$];
   int hist1[$];
   int cfg0 = 0;
   int cfg1 = 0;
   int over_exp = 0;
   int frame_no = 0;

   always #5 clk = ~clk;

   delay_and_sum #(.NUM_CHANNELS(NC), .SAMPLE_BITS(SB), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .cfg_load     (cfg_load),
      .delay_cfg    (delay_cfg),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .busy         (busy),
      .overrun      (overrun)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sum of each channel's sample from cfg frames ago; frames before reset do not exist.
   function automatic int model_sum();
      int n    = hist0.size();
      int fill = (n > DEPTH) ? DEPTH : n;
      int s    = 0;
      if (cfg0 < fill) s += hist0[n-1-cfg0];
      if (cfg1 < fill) s += hist1[n-1-cfg1];
      return s;
   endfunction

   task automatic model_clear();
      hist0.delete();
      hist1.delete();
      cfg0     = 0;
      cfg1     = 0;
      over_exp = 0;
   endtask

   task automatic load_cfg(input int d0, input int d1);
      cfg_load  = 1'b1;
      delay_cfg = {4'(d1), 4'(d0)};
      cfg0 = d0;
      cfg1 = d1;
      tick();
      cfg_load = 1'b0;
   endtask

   // Starts a frame in the current (idle) cycle. Optional cfg_load alongside it, and an
   // optional cfg_load and/or stray sample_valid in cycle ev_k (1..4) after the start.
   task automatic do_frame(input int s0, input int s1,
                           input bit st_cfg, input int sd0, input int sd1,
                           input int ev_k, input bit ev_cfg, input int ed0, input int ed1,
                           input bit ev_sv);
      int exp_sum;
      bit seen = 1'b0;
      if (st_cfg) begin
         cfg_load  = 1'b1;
         delay_cfg = {4'(sd1), 4'(sd0)};
         cfg0 = sd0;
         cfg1 = sd1;
      end
      sample_valid = 1'b1;
      sample_data  = {8'(s1), 8'(s0)};
      hist0.push_back(s0);
      hist1.push_back(s1);
      exp_sum = model_sum();
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_out_valid", int'(out_valid), 0);
      tick();
      sample_valid = 1'b0;
      cfg_load     = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == ev_k) begin
            if (ev_cfg) begin
               cfg_load  = 1'b1;
               delay_cfg = {4'(ed1), 4'(ed0)};
               cfg0 = ed0;
               cfg1 = ed1;
            end
            if (ev_sv) begin
               sample_valid = 1'b1;
               sample_data  = 16'($urandom);
               over_exp     = 1;
            end
         end
         @(negedge clk);
         if (k <= 3) chk("busy", int'(busy), 1);
         if (out_valid && !seen) begin
            seen = 1'b1;
            chk("latency", k, NC + 2);
            chk("sum", int'($signed(out_data)), exp_sum);
         end
         tick();
         sample_valid = 1'b0;
         cfg_load     = 1'b0;
         if (seen) break;
      end
      if (!seen) chk("timeout_no_out_valid", 0, 1);
      chk("overrun", int'(overrun), over_exp);
      $display("frame %0d: in=(%0d,%0d) out=%0d expected=%0d overrun=%0d",
               frame_no, s0, s1, $signed(out_data), exp_sum, overrun);
      frame_no++;
   endtask

   task automatic plain_frame(input int s0, input int s1);
      do_frame(s0, s1, 1'b0, 0, 0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      cfg_load     = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      model_clear();
      tick();
   endtask

   initial begin
      int stray;
      do_reset();

      // Basic sum with zero delays.
      plain_frame(10, -3);

      // Channel 1 delayed by two frames: masked until enough history exists.
      do_reset();
      load_cfg(0, 2);
      plain_frame(1, 5);
      plain_frame(1, 6);
      plain_frame(1, 7);

      // Extremes.
      load_cfg(0, 0);
      plain_frame(-128, -128);
      plain_frame(127, 127);

      // Wrap-around with maximum delay.
      do_reset();
      load_cfg(0, 15);
      for (int k = 0; k < 20; k++) plain_frame(0, k);

      // Stray sample_valid while busy, then confirm the pointer moved only once.
      load_cfg(0, 0);
      do_frame(3, 4, 1'b0, 0, 0, 2, 1'b0, 0, 0, 1'b1);
      load_cfg(1, 0);
      plain_frame(9, 9);

      // cfg_load mid-frame takes effect on the following frame.
      load_cfg(0, 0);
      do_frame(20, 30, 1'b0, 0, 0, 2, 1'b1, 0, 3, 1'b0);
      plain_frame(-5, 40);

      // cfg_load together with sample_valid applies to that frame.
      do_frame(11, 22, 1'b1, 1, 1, 0, 1'b0, 0, 0, 1'b0);

      // Reset while accumulating: frame aborted, outputs cleared.
      sample_valid = 1'b1;
      sample_data  = {8'(50), 8'(60)};
      tick();
      sample_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_overrun", int'(overrun), 0);
      tick();
      tick();
      rst_n = 1'b1;
      model_clear();
      stray = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      chk("midrst_no_out_valid", stray, 0);
      tick();

      // Randomised frames, configurations and stray strobes.
      for (int f = 0; f < 150; f++) begin
         int  s0, s1, ev_k;
         bit  st_cfg, ev_cfg, ev_sv;
         if ($urandom_range(0, 7) == 0) load_cfg($urandom_range(0, 15), $urandom_range(0, 15));
         s0     = int'($urandom_range(0, 255)) - 128;
         s1     = int'($urandom_range(0, 255)) - 128;
         st_cfg = ($urandom_range(0, 5) == 0);
         ev_cfg = ($urandom_range(0, 3) == 0);
         ev_sv  = ($urandom_range(0, 5) == 0);
         ev_k   = $urandom_range(1, 4);
         do_frame(s0, s1, st_cfg, $urandom_range(0, 15), $urandom_range(0, 15),
                  ev_k, ev_cfg, $urandom_range(0, 15), $urandom_range(0, 15), ev_sv);
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end
endmodule
